// File: rtl/mmx_alu_pipe.sv
// mmx_alu_pipe: two-stage elastic packed-integer ALU (wrap/saturating add
// and sub, compares, logicals) with selectable element size.
//   CLK, RST            clock, asynchronous active-high reset
//   in_valid/in_ready   operand beat handshake (op, esize, a, b)
//   out_valid/out_ready result handshake (result, sat_mask)
//   busy                a beat is held in either stage
module mmx_alu_pipe #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NLANE8 = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [1:0]        esize,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [NLANE8-1:0] sat_mask,
  output logic              busy
);

  localparam int unsigned LW = (NLANE8 > 1) ? $clog2(NLANE8) : 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDS  = 4'd1,
    OP_ADDUS = 4'd2,
    OP_SUB   = 4'd3,
    OP_SUBS  = 4'd4,
    OP_SUBUS = 4'd5,
    OP_CMPEQ = 4'd6,
    OP_CMPGT = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_XOR   = 4'd10,
    OP_ANDN  = 4'd11,
    OP_RSV12 = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } op_e;

  // Pipeline state
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  op_e               op_q, op_d;
  logic [1:0]        esize_q, esize_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [NLANE8-1:0] sat_mask_q, sat_mask_d;

  // Handshake
  logic adv2, accept, in_ready_c;

  // Byte-lane datapath
  logic                   is_sub, sat_ok, cin;
  logic [LW-1:0]          nbm1, top, base;
  logic [8:0]             tmp;
  logic [7:0]             bx, ab, bb, rbyte;
  logic [NLANE8-1:0][7:0] sum_b;
  logic [NLANE8-1:0]      ovf_s, ovf_u, eq_b, sgn_a;
  logic                   el_eq, el_lt, el_sat;
  logic [DATA_W-1:0]      res_c;
  logic [NLANE8-1:0]      sat_c;

  always_comb begin
    adv2        = s1_valid_q & (~out_valid_q | out_ready);
    in_ready_c  = ~s1_valid_q | adv2;
    accept      = in_valid & in_ready_c;

    s1_valid_d  = accept | (s1_valid_q & ~adv2);
    a_d         = accept ? a : a_q;
    b_d         = accept ? b : b_q;
    op_d        = accept ? op_e'(op) : op_q;
    esize_d     = accept ? esize : esize_q;

    out_valid_d = adv2 | (out_valid_q & ~out_ready);
    result_d    = adv2 ? res_c : result_q;
    sat_mask_d  = adv2 ? sat_c : sat_mask_q;
  end

  // Lane adder: one 8-bit slice per byte; the carry is re-seeded at every
  // element start so nothing crosses an element boundary.
  always_comb begin
    is_sub = (op_q == OP_SUB) || (op_q == OP_SUBS) ||
             (op_q == OP_SUBUS) || (op_q == OP_CMPGT);
    nbm1   = LW'((4'd1 << esize_q) - 4'd1);
    cin    = 1'b0;
    tmp    = '0;
    bx     = '0;
    sum_b  = '0;
    ovf_s  = '0;
    ovf_u  = '0;
    eq_b   = '0;
    sgn_a  = '0;
    for (int unsigned i = 0; i < NLANE8; i++) begin
      bx = is_sub ? ~b_q[8*i +: 8] : b_q[8*i +: 8];
      if ((LW'(i) & nbm1) == '0) begin
        cin = is_sub;
      end
      tmp      = {1'b0, a_q[8*i +: 8]} + {1'b0, bx} + {8'd0, cin};
      sum_b[i] = tmp[7:0];
      // carry into bit 7 is recovered from the sum bit
      ovf_s[i] = (tmp[7] ^ a_q[8*i+7] ^ bx[7]) ^ tmp[8];
      ovf_u[i] = tmp[8] ^ is_sub;
      eq_b[i]  = (a_q[8*i +: 8] == b_q[8*i +: 8]);
      sgn_a[i] = a_q[8*i+7];
      cin      = tmp[8];
    end
  end

  // Element resolve: every byte looks at its element's top byte for the
  // overflow/sign flags, so all bytes of an element clamp together.
  always_comb begin
    sat_ok = (esize_q != 2'd3);
    res_c  = '0;
    sat_c  = '0;
    top    = '0;
    base   = '0;
    el_eq  = 1'b0;
    el_lt  = 1'b0;
    el_sat = 1'b0;
    rbyte  = '0;
    ab     = '0;
    bb     = '0;
    for (int unsigned i = 0; i < NLANE8; i++) begin
      top   = LW'(i) | nbm1;
      base  = LW'(i) & ~nbm1;
      el_eq = 1'b1;
      for (int unsigned j = 0; j < NLANE8; j++) begin
        if ((LW'(j) >= base) && (LW'(j) <= top)) begin
          el_eq = el_eq & eq_b[j];
        end
      end
      el_lt  = sum_b[top][7] ^ ovf_s[top];
      el_sat = 1'b0;
      ab     = a_q[8*i +: 8];
      bb     = b_q[8*i +: 8];
      case (op_q)
        OP_ADD, OP_SUB: rbyte = sum_b[i];
        OP_ADDS, OP_SUBS: begin
          el_sat = sat_ok & ovf_s[top];
          if (el_sat) begin
            if (LW'(i) == top) rbyte = sgn_a[top] ? 8'h80 : 8'h7F;
            else               rbyte = sgn_a[top] ? 8'h00 : 8'hFF;
          end else begin
            rbyte = sum_b[i];
          end
        end
        OP_ADDUS: begin
          el_sat = sat_ok & ovf_u[top];
          rbyte  = el_sat ? 8'hFF : sum_b[i];
        end
        OP_SUBUS: begin
          el_sat = sat_ok & ovf_u[top];
          rbyte  = el_sat ? 8'h00 : sum_b[i];
        end
        OP_CMPEQ: rbyte = {8{el_eq}};
        OP_CMPGT: rbyte = {8{~el_lt & ~el_eq}};
        OP_AND:   rbyte = ab & bb;
        OP_OR:    rbyte = ab | bb;
        OP_XOR:   rbyte = ab ^ bb;
        OP_ANDN:  rbyte = ~ab & bb;
        default:  rbyte = '0;
      endcase
      res_c[8*i +: 8] = rbyte;
      sat_c[i]        = el_sat;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      esize_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_mask_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      esize_q     <= esize_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_mask_q  <= sat_mask_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat_mask  = sat_mask_q;
  assign busy      = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_mmx_alu_pipe.sv
// tb_mmx_alu_pipe: scoreboard bench for mmx_alu_pipe (DATA_W=64).
module tb_mmx_alu_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [1:0]  esize = '0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic [7:0]  sat_mask;
  logic        busy;

  mmx_alu_pipe #(.DATA_W(64)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .esize(esize), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat_mask(sat_mask), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] r;
    logic [7:0]  m;
    int          acc;
    bit          lat;
    bit          gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_pop = 0;
  int   n_acc = 0;
  bit   rand_done;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: whole-element arithmetic on wide signed/unsigned values.
  function automatic void model(input logic [3:0] o, input logic [1:0] es,
                                input logic [63:0] av, input logic [63:0] bv,
                                output logic [63:0] r, output logic [7:0] m);
    int unsigned n, nb;
    logic [63:0] mask, ua, ub, re;
    logic signed [65:0] sa, sb_, sr, smax, smin;
    logic [65:0] ur;
    logic sat;
    n    = 8 << es;
    nb   = n / 8;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    smax = $signed((66'd1 << (n - 1)) - 66'd1);
    smin = -smax - 66'sd1;
    r = '0;
    m = '0;
    for (int unsigned lo = 0; lo < 64; lo += n) begin
      ua  = (av >> lo) & mask;
      ub  = (bv >> lo) & mask;
      sa  = $signed({2'b00, ua});
      sb_ = $signed({2'b00, ub});
      if (ua[n-1]) sa  = sa  | $signed({2'b11, ~mask});
      if (ub[n-1]) sb_ = sb_ | $signed({2'b11, ~mask});
      sat = 1'b0;
      re  = '0;
      case (o)
        4'd0: re = ua + ub;
        4'd3: re = ua - ub;
        4'd1, 4'd4: begin
          sr = (o == 4'd1) ? sa + sb_ : sa - sb_;
          if (es != 2'd3 && sr > smax) begin sr = smax; sat = 1'b1; end
          else if (es != 2'd3 && sr < smin) begin sr = smin; sat = 1'b1; end
          re = sr[63:0];
        end
        4'd2: begin
          ur = {2'b00, ua} + {2'b00, ub};
          if (es != 2'd3 && ur > {2'b00, mask}) begin re = mask; sat = 1'b1; end
          else re = ur[63:0];
        end
        4'd5: begin
          if (es != 2'd3 && ua < ub) begin re = '0; sat = 1'b1; end
          else re = ua - ub;
        end
        4'd6:  re = (ua == ub) ? mask : '0;
        4'd7:  re = (sa > sb_) ? mask : '0;
        4'd8:  re = ua & ub;
        4'd9:  re = ua | ub;
        4'd10: re = ua ^ ub;
        4'd11: re = ~ua & ub;
        default: re = '0;
      endcase
      r = r | ((re & mask) << lo);
      if (sat) m = m | 8'(((1 << nb) - 1) << (lo / 8));
    end
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] o, input logic [1:0] es,
                      input logic [63:0] av, input logic [63:0] bv,
                      input logic [63:0] er, input logic [7:0] em,
                      input bit lat, input bit gap);
    exp_t e;
    int unsigned w;
    op = o; esize = es; a = av; b = bv; in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge CLK); #1; w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    e.r = er; e.m = em; e.acc = cyc; e.lat = lat; e.gap = gap;
    sb.push_back(e);
    n_acc++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic send_model(input logic [3:0] o, input logic [1:0] es,
                            input logic [63:0] av, input logic [63:0] bv,
                            input bit lat, input bit gap);
    logic [63:0] er;
    logic [7:0]  em;
    model(o, es, av, bv, er, em);
    send(o, es, av, bv, er, em, lat, gap);
  endtask

  task automatic wait_drain();
    int unsigned w;
    w = 0;
    while ((sb.size() != 0 || busy) && w < 200) begin
      @(negedge CLK); #2; w++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(negedge CLK);
  endtask

  // Output monitor: pops one expectation per output handshake.
  always @(negedge CLK) begin
    exp_t e;
    #1;
    if (!RST && out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", result, e.r);
        check("sat_mask", 64'(sat_mask), 64'(e.m));
        if (e.lat) check("latency", 64'(cyc - e.acc), 64'd2);
        if (e.gap) check("one_per_cycle", 64'(cyc - last_pop), 64'd1);
        last_pop = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] bp_a [4];
  logic [63:0] bp_b [4];
  logic [63:0] bp_r0;
  logic [7:0]  bp_m0;

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_sat_mask", 64'(sat_mask), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK);

    // Directed vectors, one beat at a time
    send(4'd0, 2'd0, 64'hFF01_7F80_0000_00FF, 64'h0101_0180_0000_0001,
         64'h0002_8000_0000_0000, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();
    send(4'd1, 2'd1, 64'h7FFF_8000_0001_1234, 64'h0001_FFFF_0001_0000,
         64'h7FFF_8000_0002_1234, 8'hF0, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();
    send(4'd5, 2'd2, 64'h0000_0005_FFFF_FFFF, 64'h0000_0009_0000_0001,
         64'h0000_0000_FFFF_FFFE, 8'hF0, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();
    send(4'd2, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();
    send(4'd7, 2'd0, 64'h01, 64'hFF, 64'h00FF, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();
    send(4'd4, 2'd0, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0001,
         64'h0000_0000_0000_0080, 8'h01, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();
    send(4'd11, 2'd0, 64'hF0F0_F0F0_0000_FFFF, 64'hFFFF_FFFF_1234_5678,
         64'h0F0F_0F0F_1234_0000, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();
    send(4'd13, 2'd1, 64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF,
         64'd0, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();

    // Back-to-back burst, no backpressure
    for (int k = 0; k < 8; k++) begin
      send_model(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, k > 0);
    end
    in_valid = 1'b0; wait_drain();

    // Backpressure: 4 beats with the consumer stalled
    for (int k = 0; k < 4; k++) begin
      bp_a[k] = {$urandom, $urandom};
      bp_b[k] = {$urandom, $urandom};
    end
    model(4'd1, 2'd0, bp_a[0], bp_b[0], bp_r0, bp_m0);
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          send_model(4'd1, 2'd0, bp_a[k], bp_b[k], 1'b0, k > 0);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(negedge CLK);
        #2;
        check("bp_accepted", 64'(n_acc), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_hold_result", result, bp_r0);
        check("bp_hold_mask", 64'(sat_mask), 64'(bp_m0));
        @(negedge CLK);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(4'd0, 2'd0, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101,
         64'h0202_0202_0202_0202, 8'h00, 1'b0, 1'b0);
    send(4'd9, 2'd0, 64'h00FF, 64'hFF00, 64'hFFFF, 8'h00, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check("pre_rst_result", result, 64'h0202_0202_0202_0202);
    #1;
    RST = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_sat_mask", 64'(sat_mask), 64'd0);
    sb.delete();
    @(negedge CLK);
    #3;
    RST = 1'b0;
    @(negedge CLK);
    out_ready = 1'b1;
    send(4'd10, 2'd2, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000,
         64'hEDCB_A987_9ABC_DEF0, 8'h00, 1'b1, 1'b0);
    in_valid = 1'b0; wait_drain();

    // Random stream with random consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          send_model(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge CLK);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmx_alu_pipe.md
Name: mmx_alu_pipe

Overview:
- Parametrised, two-stage pipelined packed-integer (MMX-class) ALU for the execute stage.
- Generalises the fixed 64-bit word/dword packed adder in four ways:
  - selectable element size;
  - wrap, signed-saturate and unsigned-saturate add/sub;
  - compares and logicals;
  - a valid/ready elastic handshake with backpressure.
- Sits between operand read (MM_A/MM_B) and writeback.

Parameters:
- DATA_W, 64, datapath width in bits; a multiple of 64.
- NLANE8, DATA_W/8, number of byte lanes (derived, not overridden).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  ALU accepts a beat this cycle
- op  in  4  operation select (see Behaviour)
- esize  in  2  element size: 0=byte, 1=word, 2=dword, 3=qword
- a  in  DATA_W  operand A
- b  in  DATA_W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  DATA_W  packed result
- sat_mask  out  NLANE8  per-byte flag; set on every byte of an element that saturated
- busy  out  1  at least one beat in flight (s1_valid | out_valid)

Behaviour:
- Reset (async, RST=1):
  - s1_valid=0, out_valid=0, result=0, sat_mask=0, busy=0.
  - in_ready is 1 combinationally once reset deasserts.
  - Reset mid-operation discards all in-flight beats, with no output pulse.
- Stage 1: on in_valid & in_ready, register a, b, op and esize; set s1_valid.
- Stage 2: compute from the stage-1 registers; register result and sat_mask; set out_valid.
- Advance rules:
  - adv2 = s1_valid & (!out_valid | out_ready)
  - in_ready = !s1_valid | adv2
- Latency is 2 cycles from acceptance to out_valid when there is no backpressure. Throughput is one beat per cycle.
- Backpressure: while out_valid & !out_ready, result and sat_mask hold stable. After one more beat is accepted into stage 1, in_ready falls.
- Simultaneous out handshake and new stage-1 beat: the stage-2 register is overwritten the same edge, with no bubble.
- out_valid clears only on out_ready when s1 is empty.
- Element arithmetic:
  - Lanes are independent; no carry crosses an element boundary of size 8<<esize.
  - Subtraction is a - b.
- op encoding:
  - 0: add wrap
  - 1: add signed saturate
  - 2: add unsigned saturate
  - 3: sub wrap
  - 4: sub signed saturate
  - 5: sub unsigned saturate
  - 6: cmpeq, element = all-ones if a==b, else 0
  - 7: cmpgt signed, element = all-ones if a>b, else 0
  - 8: and
  - 9: or
  - 10: xor
  - 11: andn, ~a & b
  - 12-15: reserved; result=0, sat_mask=0, the beat still completes the handshake
- Signed saturation clamps to [-2^(n-1), 2^(n-1)-1].
- Unsigned saturation clamps to [0, 2^n-1].
- sat_mask bits of an element are set only when clamping occurred. They are 0 for all non-saturating ops.
- qword with ops 1, 2, 4, 5 behaves as the wrap op, and sat_mask=0 (no 64-bit saturation).
- esize and op are sampled only at stage-1 acceptance. Changing them while in_ready=0 has no effect.
- busy = s1_valid | out_valid.

Test Plan:
- Byte add wrap:
  - Stimulus: esize=0, op=0, a=64'hFF01_7F80_0000_00FF, b=64'h0101_0180_0000_0001, out_ready=1.
  - Required: result=64'h0002_8000_0000_0000, sat_mask=0, out_valid exactly 2 cycles after acceptance.
- Word signed saturate:
  - Stimulus: esize=1, op=1, a=64'h7FFF_8000_0001_1234, b=64'h0001_FFFF_0001_0000.
  - Required: result=64'h7FFF_8000_0002_1234, sat_mask=8'b1111_0000.
- Dword unsigned sub saturate:
  - Stimulus: esize=2, op=5, a=64'h0000_0005_FFFF_FFFF, b=64'h0000_0009_0000_0001.
  - Required: result=64'h0000_0000_FFFF_FFFE, sat_mask=8'hF0.
- Qword sat fallback and compare:
  - Stimulus: esize=3, op=2, a=64'hFFFF_FFFF_FFFF_FFFF, b=1.
  - Required: result=0, sat_mask=0.
  - Then: esize=0, op=7, a=64'h01, b=64'hFF.
  - Required: result=64'h00FF.
- Backpressure:
  - Stimulus: stream 4 beats with in_valid=1 and out_ready=0.
  - Required: 2 beats accepted; in_ready=0 afterwards; result holds beat 1.
  - Then: raise out_ready.
  - Required: beats 2-4 emerge one per cycle, in order, with no loss or duplicate.
- Reset mid-flight:
  - Stimulus: assert RST asynchronously (between edges) with 2 beats in flight.
  - Required: out_valid, busy, result and sat_mask go 0 immediately.
  - After release: the first new beat appears 2 cycles after acceptance.
